bus_drive_ctrl: RTL and testbench

//  Upstream control stage for the single-wire tristate bus buffer (bufif1 cell).

---
 rtl/bus_drive_ctrl_if.sv | 23 ++
 rtl/bus_drive_ctrl.sv | 113 +++++++++++
 tb/tb_bus_drive_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_drive_ctrl_if.sv
// Handshake and tristate-buffer control signals of bus_drive_ctrl.
// The master side feeds words to the controller; the slave side is the controller itself.
interface bus_drive_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             bus_d;
  logic             bus_en;
  logic             busy;
  logic             done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, bus_d, bus_en, busy, done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, bus_d, bus_en, busy, done
  );
endinterface

// File: rtl/bus_drive_ctrl.sv
// Serialises handshaked words as START/DATA(LSB first)/STOP frames onto a tristate
// buffer's data/enable pins, then releases the line for GUARD turnaround cycles.
module bus_drive_ctrl #(
  parameter int WIDTH = 8,
  parameter int GUARD = 2
) (
  input  logic            clk,
  input  logic            rst,
  bus_drive_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GUARD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             bus_d_q, bus_d_d;
  logic             bus_en_q, bus_en_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = bus.tx_valid & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Payload holder carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = bus.tx_data;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_STOP;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_STOP: begin
        gcnt_d  = '0;
        state_d = (GUARD == 0) ? S_IDLE : S_GUARD;
      end
      S_GUARD: begin
        if (gcnt_q == GW'(GUARD - 1)) state_d = S_IDLE;
        else                          gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    bus_en_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    bus_d_d  = 1'b1;
    if (state_d == S_START)     bus_d_d = 1'b0;
    else if (state_d == S_DATA) bus_d_d = shift_d[0];
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_IDLE) && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_d_q  <= 1'b1;
      bus_en_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bus_d_q  <= bus_d_d;
      bus_en_q <= bus_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.bus_d    = bus_d_q;
  assign bus.bus_en   = bus_en_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_bus_drive_ctrl.sv
// Bench for bus_drive_ctrl: directed frame scenarios plus random traffic against a
// frame-level waveform model and a bus decoder scoreboard.
module tb_bus_drive_ctrl;
  localparam int W = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_drive_ctrl_if #(.WIDTH(W)) bif ();
  bus_drive_ctrl_if #(.WIDTH(1)) bif1 ();

  bus_drive_ctrl #(.WIDTH(W), .GUARD(G)) dut  (.clk(clk), .rst(rst), .bus(bif.slave));
  bus_drive_ctrl #(.WIDTH(1), .GUARD(0)) dut1 (.clk(clk), .rst(rst), .bus(bif1.slave));

  typedef struct packed {
    logic en;
    logic d;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  logic rec_en = 1'b0;
  logic mon_en = 1'b0;
  logic [W-1:0] sent_q[$];
  logic [W-1:0] dec_q[$];
  logic         burst[$];

  function automatic exp_t mk(logic en, logic d, logic busy, logic done, logic ready);
    exp_t e;
    e.en = en; e.d = d; e.busy = busy; e.done = done; e.ready = ready;
    return e;
  endfunction

  function automatic exp_t obs();
    return mk(bif.bus_en, bif.bus_d, bif.busy, bif.done, bif.tx_ready);
  endfunction

  // Reference: each accepted word expands into its whole expected waveform,
  // one entry per cycle, ending with the idle cycle that carries done.
  exp_t cur;
  exp_t fq[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      cur = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end else begin
      if (cur.ready && bif.tx_valid) begin
        if (rec_en) sent_q.push_back(bif.tx_data);
        fq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < W; i++) fq.push_back(mk(1'b1, bif.tx_data[i], 1'b1, 1'b0, 1'b0));
        fq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < G; i++) fq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        fq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
      end
      if (fq.size() > 0) cur = fq.pop_front();
      else               cur = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
  end

  // Bus decoder: every enabled burst must be START + W bits + STOP.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bif.bus_en) burst.push_back(bif.bus_d);
      else if (burst.size() > 0) begin
        logic [W-1:0] w;
        w = 'x;
        if (burst.size() == W + 2 && burst[0] == 1'b0 && burst[W+1] == 1'b1)
          for (int i = 0; i < W; i++) w[i] = burst[i+1];
        dec_q.push_back(w);
        burst.delete();
      end
    end
  end

  task automatic test_reset;
    bif.tx_data = '0; bif.tx_valid = 1'b0;
    bif1.tx_data = '0; bif1.tx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (obs() !== mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1)) begin
      n_err++; $display("FAIL reset_state got=%b want=01001", obs());
    end
    n_cmp++;
    if ({bif1.bus_en, bif1.bus_d, bif1.busy, bif1.done, bif1.tx_ready} !== 5'b01001) begin
      n_err++; $display("FAIL reset_state_w1 got=%b want=01001",
                        {bif1.bus_en, bif1.bus_d, bif1.busy, bif1.done, bif1.tx_ready});
    end
    bif.tx_data = 8'h5A; bif.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1)) begin
        n_err++; $display("FAIL reset_held_no_accept cyc=%0d got=%b want=01001", i, obs());
      end
    end
    rst = 1'b0; bif.tx_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== cur) begin n_err++; $display("FAIL reset_release got=%b want=%b", obs(), cur); end
  endtask

  task automatic test_a5;
    logic [9:0] seq;
    seq = 10'b1101001010;
    @(negedge clk); bif.tx_data = 8'hA5; bif.tx_valid = 1'b1;
    @(negedge clk); bif.tx_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if (bif.bus_en !== (i < 10) || bif.bus_d !== ((i < 10) ? seq[i] : 1'b1) ||
          bif.done !== (i == 12) || bif.busy !== (i < 12)) begin
        n_err++;
        $display("FAIL a5_frame cyc=%0d got en=%b d=%b done=%b busy=%b want en=%b d=%b done=%b busy=%b",
                 i, bif.bus_en, bif.bus_d, bif.done, bif.busy, (i < 10),
                 ((i < 10) ? seq[i] : 1'b1), (i == 12), (i < 12));
      end
      n_cmp++;
      if (obs() !== cur) begin n_err++; $display("FAIL a5_model cyc=%0d got=%b want=%b", i, obs(), cur); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2, low;
    logic pb;
    t1 = -1; t2 = -1; low = 0; pb = 1'b0;
    bif.tx_data = 8'hFF; bif.tx_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && t2 < 0; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== cur) begin n_err++; $display("FAIL b2b_model cyc=%0d got=%b want=%b", cyc, obs(), cur); end
      if (bif.busy && !pb) begin
        if (t1 < 0) begin t1 = cyc; bif.tx_data = 8'h00; end
        else begin t2 = cyc; bif.tx_valid = 1'b0; end
      end
      if (t1 >= 0 && t2 < 0 && !bif.tx_ready) low++;
      pb = bif.busy;
    end
    n_cmp++;
    if (t2 < 0 || t2 - t1 != 13) begin
      n_err++; $display("FAIL b2b_start_spacing got=%0d want=13 (t1=%0d t2=%0d)", t2 - t1, t1, t2);
    end
    n_cmp++;
    if (low != 12) begin n_err++; $display("FAIL b2b_ready_low got=%0d want=12", low); end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== cur) begin n_err++; $display("FAIL b2b_drain cyc=%0d got=%b want=%b", i, obs(), cur); end
    end
  endtask

  task automatic test_hold_data;
    logic [9:0] got;
    @(negedge clk); bif.tx_data = 8'hC3; bif.tx_valid = 1'b1;
    @(negedge clk); bif.tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      got[i] = bif.bus_d;
      n_cmp++;
      if (obs() !== cur) begin n_err++; $display("FAIL hold_model cyc=%0d got=%b want=%b", i, obs(), cur); end
      if (i == 3) bif.tx_data = 8'h3C;
      @(negedge clk);
    end
    n_cmp++;
    if (got[8:1] !== 8'hC3) begin n_err++; $display("FAIL hold_data_bits got=%h want=c3", got[8:1]); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [9:0] got;
    int dones;
    dones = 0;
    @(negedge clk); bif.tx_data = 8'h5A; bif.tx_valid = 1'b1;
    @(negedge clk); bif.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bif.bus_en, bif.bus_d, bif.busy} !== 3'b010) begin
      n_err++; $display("FAIL rst_mid_async got en/d/busy=%b want=010", {bif.bus_en, bif.bus_d, bif.busy});
    end
    @(negedge clk);
    n_cmp++;
    if (bif.done !== 1'b0 || bif.tx_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_held got done=%b ready=%b want done=0 ready=1", bif.done, bif.tx_ready);
    end
    rst = 1'b0; bif.tx_data = 8'h01; bif.tx_valid = 1'b1;
    @(negedge clk); bif.tx_valid = 1'b0;
    n_cmp++;
    if ({bif.bus_en, bif.bus_d} !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_first_accept got en/d=%b want=10", {bif.bus_en, bif.bus_d});
    end
    for (int i = 0; i < 14; i++) begin
      if (i < 10) got[i] = bif.bus_d;
      if (bif.done) dones++;
      n_cmp++;
      if (obs() !== cur) begin n_err++; $display("FAIL rst_mid_model cyc=%0d got=%b want=%b", i, obs(), cur); end
      @(negedge clk);
    end
    n_cmp++;
    if (got[8:1] !== 8'h01 || dones != 1) begin
      n_err++; $display("FAIL rst_mid_new_frame got data=%h dones=%0d want data=01 dones=1", got[8:1], dones);
    end
  endtask

  task automatic test_w1g0;
    logic [4:0] tbl [5];
    tbl = '{5'b10100, 5'b11100, 5'b11100, 5'b01011, 5'b01001};
    @(negedge clk); bif1.tx_data = 1'b1; bif1.tx_valid = 1'b1;
    @(negedge clk); bif1.tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bif1.bus_en, bif1.bus_d, bif1.busy, bif1.done, bif1.tx_ready} !== tbl[i]) begin
        n_err++; $display("FAIL w1g0_frame cyc=%0d got=%b want=%b", i,
                          {bif1.bus_en, bif1.bus_d, bif1.busy, bif1.done, bif1.tx_ready}, tbl[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int cyc;
    sent_q.delete(); dec_q.delete(); burst.delete();
    rec_en = 1'b1; mon_en = 1'b1;
    cyc = 0;
    while (sent_q.size() < 1000 && cyc < 40000) begin
      bif.tx_valid = ($urandom_range(0, 1) == 0);
      bif.tx_data  = W'($urandom);
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (obs() !== cur) begin n_err++; $display("FAIL rand_model cyc=%0d got=%b want=%b", cyc, obs(), cur); end
      n_cmp++;
      if (!bif.bus_en && bif.bus_d !== 1'b1) begin
        n_err++; $display("FAIL rand_idle_level cyc=%0d got d=%b want d=1", cyc, bif.bus_d);
      end
    end
    bif.tx_valid = 1'b0;
    rec_en = 1'b0;
    n_cmp++;
    if (sent_q.size() < 1000) begin
      n_err++; $display("FAIL rand_budget got words=%0d want=1000", sent_q.size());
    end
    repeat (16) @(negedge clk);
    mon_en = 1'b0;
    n_cmp++;
    if (dec_q.size() != sent_q.size()) begin
      n_err++; $display("FAIL rand_count got=%0d want=%0d", dec_q.size(), sent_q.size());
    end
    for (int i = 0; i < sent_q.size() && i < dec_q.size(); i++) begin
      n_cmp++;
      if (dec_q[i] !== sent_q[i]) begin
        n_err++; $display("FAIL rand_word idx=%0d got=%h want=%h", i, dec_q[i], sent_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_hold_data();
    test_reset_mid();
    test_w1g0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
